// File: rtl/matmul_pkg.sv
// Shared types and width helpers for the sequential matrix multiplier.
package matmul_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIN
    } state_t;

    function automatic int dim_width(input int max_dim);
        return $clog2(max_dim + 1);
    endfunction

    // Wide enough for MAX_DIM full-scale products without overflow.
    function automatic int acc_width(input int data_width, input int max_dim);
        return 2 * data_width + $clog2(max_dim);
    endfunction

endpackage

// File: rtl/matmul_dot_product.sv
// Combinational masked dot product of one A row and one B column.
// Result reduction: modulo 2^DATA_WIDTH, or clamp when MATMUL_SATURATE_EN is defined.
module matmul_dot_product
    import matmul_pkg::*;
#(
    parameter  int DATA_WIDTH = 9,
    parameter  int MAX_DIM    = 5,
    localparam int DIM_W      = dim_width(MAX_DIM),
    localparam int ACC_W      = acc_width(DATA_WIDTH, MAX_DIM)
) (
    input  logic [MAX_DIM*DATA_WIDTH-1:0] a_row_i,
    input  logic [MAX_DIM*DATA_WIDTH-1:0] b_col_i,
    input  logic [DIM_W-1:0]              len_i,
    output logic [DATA_WIDTH-1:0]         dot_o
);

    localparam int LANES = 1 << $clog2(MAX_DIM);

    function automatic logic [DATA_WIDTH-1:0] reduce(input logic [ACC_W-1:0] sum);
`ifdef MATMUL_SATURATE_EN
        if (|sum[ACC_W-1:DATA_WIDTH]) begin
            return '1;
        end
        return sum[DATA_WIDTH-1:0];
`else
        return sum[DATA_WIDTH-1:0];
`endif
    endfunction

    logic [ACC_W-1:0] sum;

    // Heap-ordered tree: leaves at LANES-1.., node n sums children 2n+1 and 2n+2.
    always_comb begin
        logic [ACC_W-1:0] node [2*LANES-1];
        for (int n = 0; n < 2*LANES-1; n++) begin
            node[n] = '0;
        end
        for (int k = 0; k < MAX_DIM; k++) begin
            if (k < int'(len_i)) begin
                node[LANES-1+k] = ACC_W'(a_row_i[k*DATA_WIDTH +: DATA_WIDTH])
                                * ACC_W'(b_col_i[k*DATA_WIDTH +: DATA_WIDTH]);
            end
        end
        for (int n = LANES-2; n >= 0; n--) begin
            node[n] = node[2*n+1] + node[2*n+2];
        end
        sum = node[0];
    end

    assign dot_o = reduce(sum);

endmodule

// File: rtl/matrix_mult_seq.sv
// Sequential matrix multiplier: one result element per cycle in CALC.
// MATMUL_SATURATE_EN (in matmul_dot_product) selects clamping instead of wrap-around.
module matrix_mult_seq
    import matmul_pkg::*;
#(
    parameter  int DATA_WIDTH = 9,
    parameter  int MAX_DIM    = 5,
    localparam int DIM_W      = dim_width(MAX_DIM),
    localparam int FLAT_W     = MAX_DIM * MAX_DIM * DATA_WIDTH
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              clear,
    input  logic [DIM_W-1:0]  r1,
    input  logic [DIM_W-1:0]  c1,
    input  logic [DIM_W-1:0]  r2,
    input  logic [DIM_W-1:0]  c2,
    input  logic [FLAT_W-1:0] a_flat,
    input  logic [FLAT_W-1:0] b_flat,
    output logic [FLAT_W-1:0] c_flat,
    output logic [DIM_W-1:0]  r_out,
    output logic [DIM_W-1:0]  c_out,
    output logic              busy,
    output logic              done,
    output logic              dim_err
);

    state_t             state_q, state_d;
    logic [DIM_W-1:0]   i_q, i_d, j_q, j_d;
    logic [DIM_W-1:0]   r1_q, r1_d, c1_q, c1_d, c2_q, c2_d;
    logic [DIM_W-1:0]   r_out_q, r_out_d, c_out_q, c_out_d;
    logic [FLAT_W-1:0]  c_flat_q, c_flat_d;
    logic               dim_err_q, dim_err_d;
    logic               dims_ok;
    logic [MAX_DIM*DATA_WIDTH-1:0] a_row, b_col;
    logic [DATA_WIDTH-1:0]         dot;

    function automatic logic in_range(input logic [DIM_W-1:0] d);
        return (d != '0) && (int'(d) <= MAX_DIM);
    endfunction

    assign dims_ok = (c1 == r2) && in_range(r1) && in_range(c1) && in_range(c2);

    // Row i_q of A and column j_q of B feed the dot product.
    always_comb begin
        a_row = '0;
        b_col = '0;
        for (int k = 0; k < MAX_DIM; k++) begin
            a_row[k*DATA_WIDTH +: DATA_WIDTH] =
                a_flat[(int'(i_q)*MAX_DIM + k)*DATA_WIDTH +: DATA_WIDTH];
            b_col[k*DATA_WIDTH +: DATA_WIDTH] =
                b_flat[(k*MAX_DIM + int'(j_q))*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    matmul_dot_product #(
        .DATA_WIDTH(DATA_WIDTH),
        .MAX_DIM   (MAX_DIM)
    ) u_dot (
        .a_row_i(a_row),
        .b_col_i(b_col),
        .len_i  (c1_q),
        .dot_o  (dot)
    );

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        r1_d      = r1_q;
        c1_d      = c1_q;
        c2_d      = c2_q;
        r_out_d   = r_out_q;
        c_out_d   = c_out_q;
        c_flat_d  = c_flat_q;
        dim_err_d = dim_err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (dims_ok) begin
                        state_d   = CALC;
                        r1_d      = r1;
                        c1_d      = c1;
                        c2_d      = c2;
                        r_out_d   = r1;
                        c_out_d   = c2;
                        c_flat_d  = '0;
                        dim_err_d = 1'b0;
                        i_d       = '0;
                        j_d       = '0;
                    end else begin
                        // Rejected request: flag it, keep the previous result.
                        state_d   = FIN;
                        dim_err_d = 1'b1;
                        r_out_d   = '0;
                        c_out_d   = '0;
                    end
                end else if (clear) begin
                    c_flat_d  = '0;
                    r_out_d   = '0;
                    c_out_d   = '0;
                    dim_err_d = 1'b0;
                end
            end
            CALC: begin
                c_flat_d[(int'(i_q)*MAX_DIM + int'(j_q))*DATA_WIDTH +: DATA_WIDTH] = dot;
                if (j_q == c2_q - DIM_W'(1)) begin
                    j_d = '0;
                    if (i_q == r1_q - DIM_W'(1)) begin
                        i_d     = '0;
                        state_d = FIN;
                    end else begin
                        i_d = i_q + DIM_W'(1);
                    end
                end else begin
                    j_d = j_q + DIM_W'(1);
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            i_q       <= '0;
            j_q       <= '0;
            r1_q      <= '0;
            c1_q      <= '0;
            c2_q      <= '0;
            r_out_q   <= '0;
            c_out_q   <= '0;
            c_flat_q  <= '0;
            dim_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            j_q       <= j_d;
            r1_q      <= r1_d;
            c1_q      <= c1_d;
            c2_q      <= c2_d;
            r_out_q   <= r_out_d;
            c_out_q   <= c_out_d;
            c_flat_q  <= c_flat_d;
            dim_err_q <= dim_err_d;
        end
    end

    assign c_flat  = c_flat_q;
    assign r_out   = r_out_q;
    assign c_out   = c_out_q;
    assign dim_err = dim_err_q;
    assign busy    = (state_q == CALC);
    assign done    = (state_q == FIN);

endmodule

// File: tb/tb_matrix_mult_seq.sv
// Self-checking bench for matrix_mult_seq: matrix-level reference model plus directed cases.
`timescale 1ns/1ps
module tb_matrix_mult_seq;

    localparam int DW   = 9;
    localparam int MD   = 5;
    localparam int DIMW = $clog2(MD + 1);
    localparam int FW   = MD * MD * DW;
    localparam int MAXV = (1 << DW) - 1;
`ifdef MATMUL_SATURATE_EN
    localparam int EXP_300 = 511;
`else
    localparam int EXP_300 = 464;
`endif

    logic            clk     = 1'b0;
    logic            reset_n = 1'b0;
    logic            start   = 1'b0;
    logic            clear   = 1'b0;
    logic [DIMW-1:0] r1 = '0, c1 = '0, r2 = '0, c2 = '0;
    logic [FW-1:0]   a_flat = '0, b_flat = '0;
    logic [FW-1:0]   c_flat;
    logic [DIMW-1:0] r_out, c_out;
    logic            busy, done, dim_err;

    int ma [MD][MD];
    int mb [MD][MD];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    matrix_mult_seq #(.DATA_WIDTH(DW), .MAX_DIM(MD)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .clear(clear),
        .r1(r1), .c1(c1), .r2(r2), .c2(c2),
        .a_flat(a_flat), .b_flat(b_flat), .c_flat(c_flat),
        .r_out(r_out), .c_out(c_out),
        .busy(busy), .done(done), .dim_err(dim_err)
    );

    task automatic chk(input string nm, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, req, $time);
        end
    endtask

    function automatic int elem(input logic [FW-1:0] v, input int idx);
        return int'(v[idx*DW +: DW]);
    endfunction

    // Plain matrix arithmetic on the bench's own operand arrays.
    function automatic int model_elem(input int i, input int j, input int n);
        longint s = 0;
        for (int k = 0; k < n; k++) s += longint'(ma[i][k]) * longint'(mb[k][j]);
`ifdef MATMUL_SATURATE_EN
        if (s > MAXV) s = MAXV;
`else
        s = s % (MAXV + 1);
`endif
        return int'(s);
    endfunction

    function automatic bit legal(input int a, input int b, input int c, input int d);
        return (b == c) && a >= 1 && a <= MD && b >= 1 && b <= MD && d >= 1 && d <= MD;
    endfunction

    // Reference model: busy for rows*cols cycles after an accepted start, then a done cycle.
    int m_left;
    bit m_done, m_err;
    int m_r, m_cc;
    int m_c [MD*MD];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_left <= 0; m_done <= 0; m_err <= 0; m_r <= 0; m_cc <= 0;
            for (int n = 0; n < MD*MD; n++) m_c[n] <= 0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) m_done <= 1;
        end else if (m_done) begin
            m_done <= 0;
        end else if (start) begin
            if (legal(int'(r1), int'(c1), int'(r2), int'(c2))) begin
                m_left <= int'(r1) * int'(c2);
                m_err  <= 0;
                m_r    <= int'(r1);
                m_cc   <= int'(c2);
                for (int i = 0; i < MD; i++)
                    for (int j = 0; j < MD; j++)
                        m_c[i*MD+j] <= (i < int'(r1) && j < int'(c2)) ? model_elem(i, j, int'(c1)) : 0;
            end else begin
                m_done <= 1; m_err <= 1; m_r <= 0; m_cc <= 0;
            end
        end else if (clear) begin
            m_err <= 0; m_r <= 0; m_cc <= 0;
            for (int n = 0; n < MD*MD; n++) m_c[n] <= 0;
        end
    end

    always @(negedge clk) begin
        logic [FW-1:0] exp_c;
        chk("busy", busy, m_left > 0);
        chk("done", done, m_done);
        chk("dim_err", dim_err, m_err);
        chk("r_out", r_out, m_r);
        chk("c_out", c_out, m_cc);
        if (m_left == 0) begin
            for (int n = 0; n < MD*MD; n++) exp_c[n*DW +: DW] = DW'(m_c[n]);
            checks++;
            if (c_flat !== exp_c) begin
                errors++;
                $display("FAIL c_flat actual=%h required=%h at %0t", c_flat, exp_c, $time);
            end
        end
    end

    task automatic clear_ops();
        for (int i = 0; i < MD; i++)
            for (int j = 0; j < MD; j++) begin
                ma[i][j] = 0;
                mb[i][j] = 0;
            end
    endtask

    task automatic pack_ops();
        for (int i = 0; i < MD; i++)
            for (int j = 0; j < MD; j++) begin
                a_flat[(i*MD+j)*DW +: DW] = DW'(ma[i][j]);
                b_flat[(i*MD+j)*DW +: DW] = DW'(mb[i][j]);
            end
    endtask

    // Caller is positioned just after a rising edge; start is sampled on the next one.
    task automatic launch(input int a, input int b, input int c, input int d, input bit clr);
        r1 = DIMW'(a); c1 = DIMW'(b); r2 = DIMW'(c); c2 = DIMW'(d);
        start = 1'b1;
        clear = clr;
        @(posedge clk); #1;
        start = 1'b0;
        clear = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int exp_lat, input int exp_busy);
        int lat = 0;
        int bcnt = 0;
        bit seen = 0;
        while (!seen && lat < 200) begin
            @(negedge clk);
            lat++;
            if (busy) bcnt++;
            if (done) seen = 1;
        end
        chk({nm, " latency"}, seen ? lat : -1, exp_lat);
        chk({nm, " busy cycles"}, bcnt, exp_busy);
    endtask

    initial begin
        int dcnt;
        repeat (3) @(posedge clk);
        #1;
        chk("reset c_flat zero", c_flat == '0, 1);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset r_out", r_out, 0);

        // 2x3 * 3x2, started on the first edge after reset release
        clear_ops();
        for (int i = 0; i < 2; i++) for (int k = 0; k < 3; k++) ma[i][k] = i*3 + k + 1;
        for (int k = 0; k < 3; k++) for (int j = 0; j < 2; j++) mb[k][j] = 7 + k*2 + j;
        pack_ops();
        reset_n = 1'b1;
        launch(2, 3, 3, 2, 0);
        wait_done("2x3*3x2", 5, 4);
        chk("C00", elem(c_flat, 0), 58);
        chk("C01", elem(c_flat, 1), 64);
        chk("C10", elem(c_flat, 5), 139);
        chk("C11", elem(c_flat, 6), 154);
        chk("C02 outside", elem(c_flat, 2), 0);
        chk("r_out 2x2", r_out, 2);
        chk("c_out 2x2", c_out, 2);

        // Illegal dims: c1 != r2
        @(posedge clk); #1;
        launch(2, 3, 2, 2, 0);
        wait_done("illegal", 1, 0);
        chk("illegal dim_err", dim_err, 1);
        chk("illegal keeps C00", elem(c_flat, 0), 58);
        chk("illegal r_out", r_out, 0);

        // 5x5 all 300: wide sum 450000
        for (int i = 0; i < MD; i++) for (int j = 0; j < MD; j++) begin
            ma[i][j] = 300; mb[i][j] = 300;
        end
        pack_ops();
        @(posedge clk); #1;
        launch(5, 5, 5, 5, 0);
        wait_done("5x5 300", 26, 25);
        chk("5x5 C00", elem(c_flat, 0), EXP_300);
        chk("5x5 C44", elem(c_flat, 24), EXP_300);
        chk("5x5 dim_err cleared", dim_err, 0);

        // 1x1 with clear asserted alongside start: start wins
        clear_ops();
        ma[0][0] = 3; mb[0][0] = 4;
        pack_ops();
        @(posedge clk); #1;
        launch(1, 1, 1, 1, 1);
        wait_done("1x1", 2, 1);
        chk("1x1 C00", elem(c_flat, 0), 12);
        chk("1x1 C01", elem(c_flat, 1), 0);
        chk("1x1 r_out", r_out, 1);

        // Second start during CALC is dropped
        clear_ops();
        for (int i = 0; i < 2; i++) for (int k = 0; k < 3; k++) ma[i][k] = i*3 + k + 1;
        for (int k = 0; k < 3; k++) for (int j = 0; j < 2; j++) mb[k][j] = 7 + k*2 + j;
        pack_ops();
        @(posedge clk); #1;
        launch(2, 3, 3, 2, 0);
        launch(1, 1, 1, 1, 0);
        dcnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("dup start done count", dcnt, 1);
        chk("dup start C10", elem(c_flat, 5), 139);

        // Reset mid-CALC aborts with no trailing done
        @(posedge clk); #1;
        launch(5, 5, 5, 5, 0);
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        chk("abort c_flat zero", c_flat == '0, 1);
        chk("abort r_out", r_out, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        dcnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("abort no done", dcnt, 0);

        // Build up a result and an error, then clear both
        @(posedge clk); #1;
        launch(2, 3, 3, 2, 0);
        wait_done("pre-clear", 5, 4);
        @(posedge clk); #1;
        launch(3, 2, 3, 2, 0);
        wait_done("pre-clear illegal", 1, 0);
        chk("pre-clear dim_err", dim_err, 1);
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        @(negedge clk);
        chk("clear c_flat zero", c_flat == '0, 1);
        chk("clear dim_err", dim_err, 0);
        chk("clear r_out", r_out, 0);
        chk("clear c_out", c_out, 0);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
